pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequences IF/ID, ID/EX and EX/MEM pipeline registers: per-cycle write enables and bubble (NOP) inserts.
//  Detects load-use/RAW hazards, flushes on a taken branch resolved in MEM, freezes the pipe on data-memory wait.
//  Optionally drives EX-stage operand forwarding selects. Sits beside the datapath; consumes stage-register outputs.
// PARAMETERS
//  RA_W      3   register address width; address 0 is never a hazard source
//  MAX_WAIT  15  consecutive mem_busy cycles before err is set
//  CNT_W     16  width of stall_cnt and flush_cnt
// PORTS
//  clk              in   1      rising-edge clock
//  rst              in   1      synchronous reset, active high
//  id_rs, id_rt     in   RA_W   source regs of the instruction in ID (IF/ID outputs)
//  id_uses_rt       in   1      ID instruction reads rt
//  ex_rs, ex_rt     in   RA_W   source regs of the instruction in EX (ID/EX outputs)
//  ex_reg_write     in   RA_W   EX dest reg;   ex_wb_we in 1: EX writes back
//  ex_mem_read      in   1      EX instruction is a load
//  mem_reg_write    in   RA_W   EX/MEM dest reg;   mem_wb_we in 1
//  wb_reg_write     in   RA_W   MEM/WB dest reg;   wb_wb_we in 1
//  mem_pc_src       in   1      branch in MEM (EX/MEM output);   mem_zero in 1
//  mem_busy         in   1      data memory not ready this cycle
//  pc_write, ifid_write, idex_write, exmem_write   out 1   stage load enables
//  ifid_flush, idex_bubble, exmem_bubble           out 1   load NOP into that register
//  fwd_a, fwd_b     out  2      EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
//  state            out  2      00 RUN, 01 WAIT, 10 FLUSH
//  stall_cnt, flush_cnt  out CNT_W   saturating event counters;   err out 1: sticky watchdog
// BEHAVIOUR
//  Reset (rst=1 at edge): state=RUN, counters=0, err=0, wait counter=0. While rst high: all enables=1, all bubbles/flush=1, fwd=00.
//  Outputs combinational from registered state + inputs; state/counters update on the clock edge. Priority (high->low):
//   1 WAIT  : mem_busy=1 -> all enables 0, no bubbles (freeze); state=WAIT; wait_cnt++; wait_cnt==MAX_WAIT -> err=1 (sticky, pipe stays frozen).
//             mem_busy=0 in WAIT -> evaluate rules 2-4 in that same cycle; wait_cnt=0.
//   2 TAKEN : mem_pc_src & mem_zero -> all enables 1, ifid_flush=idex_bubble=exmem_bubble=1; next state=FLUSH; flush_cnt++.
//             Branch seen during mem_busy is held (EX/MEM frozen) and taken on the first non-busy cycle.
//   3 STALL : hazard (below) and state!=FLUSH -> pc_write=ifid_write=0, idex_bubble=1, exmem_write=1; stall_cnt++.
//   4 RUN   : all enables 1, no bubbles.
//  FLUSH lasts exactly one cycle: ID holds a NOP, hazard detection suppressed, then RUN.
//  Match(x,d,we) = we & (d!=0) & (d==x); rt compared only if id_uses_rt.
//  Counters saturate at all-ones; err cleared only by rst. rst mid-stall/mid-wait -> RUN next cycle.
//  Simultaneous mem_busy + taken branch: WAIT wins. Taken branch + load-use: TAKEN wins, no stall counted.
// CONFIGURATION
//  FORWARDING_EN defined:
//   hazard = ex_mem_read & Match(id_rs/id_rt, ex_reg_write, ex_wb_we) -> exactly 1 stall cycle per load-use.
//   fwd_a: 10 if Match(ex_rs,mem_reg_write,mem_wb_we), else 01 if Match(ex_rs,wb_reg_write,wb_wb_we), else 00; fwd_b same on ex_rt.
//   fwd outputs are 00 while stalled by WAIT? No: fwd always reflects current EX contents.
//  FORWARDING_EN undefined:
//   fwd_a=fwd_b=00 constant; hazard = Match against EX, MEM and WB destinations (any writer);
//   dependence on EX dest -> 3 stall cycles, MEM -> 2, WB -> 1 (regfile does not write-before-read).
// TESTING
//  T1 rst=1 two cycles -> state=00, counters 0, err 0, all enables and bubbles 1; rst=0 idle -> enables 1, bubbles 0.
//  T2 FWD on: load r3 in EX (ex_mem_read=1, ex_reg_write=3), id_rs=3 -> one cycle pc_write=0, idex_bubble=1; stall_cnt=1; next cycle RUN.
//  T3 mem_pc_src=1, mem_zero=1 -> ifid_flush=idex_bubble=exmem_bubble=1, state=10 next cycle, flush_cnt=1; branch with zero=0 -> no flush.
//  T4 mem_busy high 15 cycles with MAX_WAIT=15 -> all enables 0 throughout, err=1, remains 1 after busy drops until rst.
//  T5 FWD on: mem dest=2 (we=1), wb dest=2 (we=1), ex_rs=2 -> fwd_a=10; mem we=0 -> fwd_a=01; ex_rs=0 dest=0 -> fwd_a=00.
//  T6 FWD off: ALU writes r5 in EX, id_rs=5 -> 3 consecutive stall cycles, stall_cnt=3; mem_busy + taken branch same cycle -> freeze first, flush on release.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: hazard, flush and freeze sequencing for the IF/ID,
// ID/EX and EX/MEM pipeline registers of a 5-stage in-order pipe.
// Optional feature macro: FORWARDING_EN. When it is defined, EX-stage operand
// forwarding selects are driven and only load-use dependences stall. When it
// is undefined, forwarding selects stay 00 and any RAW dependence on a value
// still in flight (EX, MEM or WB) stalls.
module pipeline_hazard_ctrl #(
    parameter int unsigned RA_W     = 3,
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RA_W-1:0]  id_rs_i,
    input  logic [RA_W-1:0]  id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic [RA_W-1:0]  ex_rs_i,
    input  logic [RA_W-1:0]  ex_rt_i,
    input  logic [RA_W-1:0]  ex_reg_write_i,
    input  logic             ex_wb_we_i,
    input  logic             ex_mem_read_i,
    input  logic [RA_W-1:0]  mem_reg_write_i,
    input  logic             mem_wb_we_i,
    input  logic [RA_W-1:0]  wb_reg_write_i,
    input  logic             wb_wb_we_i,
    input  logic             mem_pc_src_i,
    input  logic             mem_zero_i,
    input  logic             mem_busy_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             idex_write_o,
    output logic             exmem_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             exmem_bubble_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             err_o
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_WAIT  = 2'b01,
        ST_FLUSH = 2'b10
    } state_e;

    state_e             state_q,     state_d;
    logic [WAIT_W-1:0]  wait_cnt_q,  wait_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic               err_q,       err_d;

    logic               hazard;
    logic               taken;
    logic               stall;
    logic [1:0]         fwd_a_raw;
    logic [1:0]         fwd_b_raw;
    logic [WAIT_W-1:0]  wait_inc;

    // Register 0 is hardwired, so a write to it never creates a dependence.
    function automatic logic match(input logic [RA_W-1:0] x,
                                   input logic [RA_W-1:0] d,
                                   input logic            we);
        return we && (d != '0) && (d == x);
    endfunction

`ifdef FORWARDING_EN
    // Only a load in EX cannot be forwarded in time; everything else is bypassed.
    always_comb begin
        hazard = ex_mem_read_i &&
                 (match(id_rs_i, ex_reg_write_i, ex_wb_we_i) ||
                  (id_uses_rt_i && match(id_rt_i, ex_reg_write_i, ex_wb_we_i)));
    end

    // EX/MEM result is the younger value, so it takes precedence over MEM/WB.
    always_comb begin
        if (match(ex_rs_i, mem_reg_write_i, mem_wb_we_i))
            fwd_a_raw = 2'b10;
        else if (match(ex_rs_i, wb_reg_write_i, wb_wb_we_i))
            fwd_a_raw = 2'b01;
        else
            fwd_a_raw = 2'b00;
        if (match(ex_rt_i, mem_reg_write_i, mem_wb_we_i))
            fwd_b_raw = 2'b10;
        else if (match(ex_rt_i, wb_reg_write_i, wb_wb_we_i))
            fwd_b_raw = 2'b01;
        else
            fwd_b_raw = 2'b00;
    end
`else
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{ex_rs_i, ex_rt_i, ex_mem_read_i};

    // Without bypassing, ID waits until the producer has left WB; the stall
    // length (3/2/1) follows from the producer advancing one stage per stall.
    always_comb begin
        hazard = match(id_rs_i, ex_reg_write_i,  ex_wb_we_i)  ||
                 match(id_rs_i, mem_reg_write_i, mem_wb_we_i) ||
                 match(id_rs_i, wb_reg_write_i,  wb_wb_we_i)  ||
                 (id_uses_rt_i &&
                  (match(id_rt_i, ex_reg_write_i,  ex_wb_we_i)  ||
                   match(id_rt_i, mem_reg_write_i, mem_wb_we_i) ||
                   match(id_rt_i, wb_reg_write_i,  wb_wb_we_i)));
        fwd_a_raw = 2'b00;
        fwd_b_raw = 2'b00;
    end
`endif

    assign taken = mem_pc_src_i && mem_zero_i;
    // The cycle after a flush ID holds a NOP, so its register fields are stale.
    assign stall = hazard && (state_q != ST_FLUSH);

    // Per-cycle stage controls; priority is reset, freeze, taken branch, stall.
    always_comb begin
        pc_write_o     = 1'b1;
        ifid_write_o   = 1'b1;
        idex_write_o   = 1'b1;
        exmem_write_o  = 1'b1;
        ifid_flush_o   = 1'b0;
        idex_bubble_o  = 1'b0;
        exmem_bubble_o = 1'b0;
        fwd_a_o        = fwd_a_raw;
        fwd_b_o        = fwd_b_raw;
        if (rst) begin
            ifid_flush_o   = 1'b1;
            idex_bubble_o  = 1'b1;
            exmem_bubble_o = 1'b1;
            fwd_a_o        = 2'b00;
            fwd_b_o        = 2'b00;
        end else if (mem_busy_i) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_write_o  = 1'b0;
            exmem_write_o = 1'b0;
        end else if (taken) begin
            ifid_flush_o   = 1'b1;
            idex_bubble_o  = 1'b1;
            exmem_bubble_o = 1'b1;
        end else if (stall) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
        end
    end

    assign wait_inc = (wait_cnt_q == WAIT_W'(MAX_WAIT)) ? wait_cnt_q : wait_cnt_q + 1'b1;

    // Next state, watchdog and saturating event counters.
    always_comb begin
        state_d     = ST_RUN;
        wait_cnt_d  = '0;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        err_d       = err_q;
        if (mem_busy_i) begin
            state_d    = ST_WAIT;
            wait_cnt_d = wait_inc;
            if (wait_inc == WAIT_W'(MAX_WAIT))
                err_d = 1'b1;
        end else if (taken) begin
            state_d = ST_FLUSH;
            if (flush_cnt_q != '1)
                flush_cnt_d = flush_cnt_q + 1'b1;
        end else if (stall) begin
            if (stall_cnt_q != '1)
                stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            err_q       <= err_d;
        end
    end

    assign state_o     = state_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl. Expected stage controls are queued as
// each cycle's stimulus is applied and popped when the outputs are sampled on
// the falling edge; registered state/counters are checked just after the
// rising edge. Build with +define+FORWARDING_EN for the forwarding variant.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned RA_W  = 3;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned RW    = 2 * CNT_W + 3;

    // {pc_write, ifid_write, idex_write, exmem_write,
    //  ifid_flush, idex_bubble, exmem_bubble, fwd_a, fwd_b}
    localparam logic [10:0] CTL_RUN   = 11'b1111_000_00_00;
    localparam logic [10:0] CTL_RST   = 11'b1111_111_00_00;
    localparam logic [10:0] CTL_TAKEN = 11'b1111_111_00_00;
    localparam logic [10:0] CTL_FRZ   = 11'b0000_000_00_00;
    localparam logic [10:0] CTL_STALL = 11'b0011_010_00_00;

    localparam logic [1:0] S_RUN = 2'b00, S_WAIT = 2'b01, S_FLUSH = 2'b10;

    logic clk = 1'b0;
    logic rst;
    logic [RA_W-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_reg_write, mem_reg_write, wb_reg_write;
    logic id_uses_rt, ex_wb_we, ex_mem_read, mem_wb_we, wb_wb_we;
    logic mem_pc_src, mem_zero, mem_busy;
    logic pc_write, ifid_write, idex_write, exmem_write;
    logic ifid_flush, idex_bubble, exmem_bubble;
    logic [1:0] fwd_a, fwd_b, state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic err;

    int n_pass  = 0;
    int n_total = 0;

    logic [10:0]   exp_q[$];
    logic [10:0]   got_c, want_c;
    logic [RW-1:0] got_r;

    pipeline_hazard_ctrl #(.RA_W(RA_W), .MAX_WAIT(15), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
        .ex_rs_i(ex_rs), .ex_rt_i(ex_rt), .ex_reg_write_i(ex_reg_write),
        .ex_wb_we_i(ex_wb_we), .ex_mem_read_i(ex_mem_read),
        .mem_reg_write_i(mem_reg_write), .mem_wb_we_i(mem_wb_we),
        .wb_reg_write_i(wb_reg_write), .wb_wb_we_i(wb_wb_we),
        .mem_pc_src_i(mem_pc_src), .mem_zero_i(mem_zero), .mem_busy_i(mem_busy),
        .pc_write_o(pc_write), .ifid_write_o(ifid_write),
        .idex_write_o(idex_write), .exmem_write_o(exmem_write),
        .ifid_flush_o(ifid_flush), .idex_bubble_o(idex_bubble),
        .exmem_bubble_o(exmem_bubble),
        .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .state_o(state),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .err_o(err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached (%0d/%0d done)", n_pass, n_total);
        $fatal(1, "time limit");
    end

    function automatic logic [RW-1:0] regs(input logic [1:0] st, input int sc,
                                           input int fc, input logic e);
        return {st, CNT_W'(sc), CNT_W'(fc), e};
    endfunction

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
        ex_rs = '0; ex_rt = '0; ex_reg_write = '0; ex_wb_we = 1'b0; ex_mem_read = 1'b0;
        mem_reg_write = '0; mem_wb_we = 1'b0; wb_reg_write = '0; wb_wb_we = 1'b0;
        mem_pc_src = 1'b0; mem_zero = 1'b0; mem_busy = 1'b0;
    endtask

    // Queue the expected controls for the inputs currently applied, sample on
    // the falling edge, then let the rising edge update the registered state.
    task automatic run_cycle(input logic [10:0] exp_ctl);
        exp_q.push_back(exp_ctl);
        @(negedge clk);
        got_c  = {pc_write, ifid_write, idex_write, exmem_write,
                  ifid_flush, idex_bubble, exmem_bubble, fwd_a, fwd_b};
        want_c = exp_q.pop_front();
        @(posedge clk);
        #1;
        got_r = {state, stall_cnt, flush_cnt, err};
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (i == 1) begin
                mem_busy = 1'b1; mem_pc_src = 1'b1; mem_zero = 1'b1;
                id_rs = 3'd2; ex_reg_write = 3'd2; ex_wb_we = 1'b1; ex_mem_read = 1'b1;
            end
            run_cycle(CTL_RST);
            n_total++; if (got_c !== want_c) $display("FAIL reset_ctl[%0d] got=%b exp=%b", i, got_c, want_c); else n_pass++;
            n_total++; if (got_r !== regs(S_RUN, 0, 0, 0)) $display("FAIL reset_regs[%0d] got=%b exp=%b", i, got_r, regs(S_RUN, 0, 0, 0)); else n_pass++;
        end
        rst = 1'b0;
        clear_inputs();
        run_cycle(CTL_RUN);
        n_total++; if (got_c !== want_c) $display("FAIL idle_ctl got=%b exp=%b", got_c, want_c); else n_pass++;
        n_total++; if (got_r !== regs(S_RUN, 0, 0, 0)) $display("FAIL idle_regs got=%b exp=%b", got_r, regs(S_RUN, 0, 0, 0)); else n_pass++;
    endtask

    task automatic test_branch();
        do_reset();
        mem_pc_src = 1'b1; mem_zero = 1'b1;
        run_cycle(CTL_TAKEN);
        n_total++; if (got_c !== want_c) $display("FAIL taken_ctl got=%b exp=%b", got_c, want_c); else n_pass++;
        n_total++; if (got_r !== regs(S_FLUSH, 0, 1, 0)) $display("FAIL taken_regs got=%b exp=%b", got_r, regs(S_FLUSH, 0, 1, 0)); else n_pass++;
        // hazard-looking inputs during the FLUSH cycle must not stall
        clear_inputs();
        id_rs = 3'd4; ex_reg_write = 3'd4; ex_wb_we = 1'b1; ex_mem_read = 1'b1;
        run_cycle(CTL_RUN);
        n_total++; if (got_c !== want_c) $display("FAIL flush_suppress_ctl got=%b exp=%b", got_c, want_c); else n_pass++;
        n_total++; if (got_r !== regs(S_RUN, 0, 1, 0)) $display("FAIL flush_suppress_regs got=%b exp=%b", got_r, regs(S_RUN, 0, 1, 0)); else n_pass++;
        run_cycle(CTL_STALL);
        n_total++; if (got_c !== want_c) $display("FAIL after_flush_stall_ctl got=%b exp=%b", got_c, want_c); else n_pass++;
        n_total++; if (got_r !== regs(S_RUN, 1, 1, 0)) $display("FAIL after_flush_stall_regs got=%b exp=%b", got_r, regs(S_RUN, 1, 1, 0)); else n_pass++;
        clear_inputs();
        mem_pc_src = 1'b1; mem_zero = 1'b0;
        run_cycle(CTL_RUN);
        n_total++; if (got_c !== want_c) $display("FAIL not_taken_ctl got=%b exp=%b", got_c, want_c); else n_pass++;
        mem_pc_src = 1'b0; mem_zero = 1'b1;
        run_cycle(CTL_RUN);
        n_total++; if (got_c !== want_c) $display("FAIL zero_only_ctl got=%b exp=%b", got_c, want_c); else n_pass++;
        n_total++; if (got_r !== regs(S_RUN, 1, 1, 0)) $display("FAIL not_taken_regs got=%b exp=%b", got_r, regs(S_RUN, 1, 1, 0)); else n_pass++;
        // taken branch beats a simultaneous load-use stall
        mem_pc_src = 1'b1; mem_zero = 1'b1;
        id_rs = 3'd4; ex_reg_write = 3'd4; ex_wb_we = 1'b1; ex_mem_read = 1'b1;
        run_cycle(CTL_TAKEN);
        n_total++; if (got_c !== want_c) $display("FAIL taken_vs_stall_ctl got=%b exp=%b", got_c, want_c); else n_pass++;
        n_total++; if (got_r !== regs(S_FLUSH, 1, 2, 0)) $display("FAIL taken_vs_stall_regs got=%b exp=%b", got_r, regs(S_FLUSH, 1, 2, 0)); else n_pass++;
        clear_inputs();
        run_cycle(CTL_RUN);
        n_total++; if (got_r !== regs(S_RUN, 1, 2, 0)) $display("FAIL flush_one_cycle got=%b exp=%b", got_r, regs(S_RUN, 1, 2, 0)); else n_pass++;
    endtask

    task automatic test_wait_watchdog();
        do_reset();
        mem_busy = 1'b1;
        for (int i = 0; i < 15; i++) begin
            run_cycle(CTL_FRZ);
            n_total++; if (got_c !== want_c) $display("FAIL wait_ctl[%0d] got=%b exp=%b", i, got_c, want_c); else n_pass++;
            n_total++; if (got_r !== regs(S_WAIT, 0, 0, (i == 14))) $display("FAIL wait_regs[%0d] got=%b exp=%b", i, got_r, regs(S_WAIT, 0, 0, (i == 14))); else n_pass++;
        end
        mem_busy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            run_cycle(CTL_RUN);
            n_total++; if (got_c !== want_c) $display("FAIL release_ctl[%0d] got=%b exp=%b", i, got_c, want_c); else n_pass++;
            n_total++; if (got_r !== regs(S_RUN, 0, 0, 1)) $display("FAIL err_sticky[%0d] got=%b exp=%b", i, got_r, regs(S_RUN, 0, 0, 1)); else n_pass++;
        end
        // reset in the middle of a wait returns to RUN and clears err
        mem_busy = 1'b1;
        run_cycle(CTL_FRZ);
        rst = 1'b1;
        run_cycle(CTL_RST);
        n_total++; if (got_c !== want_c) $display("FAIL rst_mid_wait_ctl got=%b exp=%b", got_c, want_c); else n_pass++;
        n_total++; if (got_r !== regs(S_RUN, 0, 0, 0)) $display("FAIL rst_mid_wait_regs got=%b exp=%b", got_r, regs(S_RUN, 0, 0, 0)); else n_pass++;
        rst = 1'b0;
        // a single ready cycle restarts the watchdog count
        for (int i = 0; i < 14; i++) run_cycle(CTL_FRZ);
        mem_busy = 1'b0;
        run_cycle(CTL_RUN);
        mem_busy = 1'b1;
        for (int i = 0; i < 14; i++) run_cycle(CTL_FRZ);
        n_total++; if (got_r !== regs(S_WAIT, 0, 0, 0)) $display("FAIL wait_restart_14 got=%b exp=%b", got_r, regs(S_WAIT, 0, 0, 0)); else n_pass++;
        run_cycle(CTL_FRZ);
        n_total++; if (got_r !== regs(S_WAIT, 0, 0, 1)) $display("FAIL wait_restart_15 got=%b exp=%b", got_r, regs(S_WAIT, 0, 0, 1)); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_busy_branch();
        do_reset();
        mem_busy = 1'b1; mem_pc_src = 1'b1; mem_zero = 1'b1;
        run_cycle(CTL_FRZ);
        n_total++; if (got_c !== want_c) $display("FAIL busy_branch_ctl got=%b exp=%b", got_c, want_c); else n_pass++;
        n_total++; if (got_r !== regs(S_WAIT, 0, 0, 0)) $display("FAIL busy_branch_regs got=%b exp=%b", got_r, regs(S_WAIT, 0, 0, 0)); else n_pass++;
        mem_busy = 1'b0;
        run_cycle(CTL_TAKEN);
        n_total++; if (got_c !== want_c) $display("FAIL branch_release_ctl got=%b exp=%b", got_c, want_c); else n_pass++;
        n_total++; if (got_r !== regs(S_FLUSH, 0, 1, 0)) $display("FAIL branch_release_regs got=%b exp=%b", got_r, regs(S_FLUSH, 0, 1, 0)); else n_pass++;
        // a hazard during a freeze is not counted as a stall
        clear_inputs();
        mem_busy = 1'b1;
        id_rs = 3'd3; ex_reg_write = 3'd3; ex_wb_we = 1'b1; ex_mem_read = 1'b1;
        run_cycle(CTL_FRZ);
        n_total++; if (got_c !== want_c) $display("FAIL busy_hazard_ctl got=%b exp=%b", got_c, want_c); else n_pass++;
        n_total++; if (got_r !== regs(S_WAIT, 0, 1, 0)) $display("FAIL busy_hazard_regs got=%b exp=%b", got_r, regs(S_WAIT, 0, 1, 0)); else n_pass++;
        mem_busy = 1'b0;
        run_cycle(CTL_STALL);
        n_total++; if (got_c !== want_c) $display("FAIL wait_to_stall_ctl got=%b exp=%b", got_c, want_c); else n_pass++;
        n_total++; if (got_r !== regs(S_RUN, 1, 1, 0)) $display("FAIL wait_to_stall_regs got=%b exp=%b", got_r, regs(S_RUN, 1, 1, 0)); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        id_rs = 3'd1; ex_reg_write = 3'd1; ex_wb_we = 1'b1; ex_mem_read = 1'b1;
        for (int i = 0; i < 18; i++) begin
            run_cycle(CTL_STALL);
            n_total++; if (got_r !== regs(S_RUN, (i >= 14) ? 15 : i + 1, 0, 0)) $display("FAIL stall_sat[%0d] got=%b exp=%b", i, got_r, regs(S_RUN, (i >= 14) ? 15 : i + 1, 0, 0)); else n_pass++;
        end
        n_total++; if (got_c !== want_c) $display("FAIL stall_sat_ctl got=%b exp=%b", got_c, want_c); else n_pass++;
        clear_inputs();
    endtask

`ifdef FORWARDING_EN
    task automatic test_load_use();
        do_reset();
        ex_mem_read = 1'b1; ex_reg_write = 3'd3; ex_wb_we = 1'b1; id_rs = 3'd3;
        run_cycle(CTL_STALL);
        n_total++; if (got_c !== want_c) $display("FAIL load_use_ctl got=%b exp=%b", got_c, want_c); else n_pass++;
        n_total++; if (got_r !== regs(S_RUN, 1, 0, 0)) $display("FAIL load_use_regs got=%b exp=%b", got_r, regs(S_RUN, 1, 0, 0)); else n_pass++;
        // bubble now in EX, load in MEM: the held ID instruction proceeds
        ex_mem_read = 1'b0; ex_reg_write = '0; ex_wb_we = 1'b0;
        mem_reg_write = 3'd3; mem_wb_we = 1'b1;
        run_cycle(CTL_RUN);
        n_total++; if (got_c !== want_c) $display("FAIL load_use_once_ctl got=%b exp=%b", got_c, want_c); else n_pass++;
        n_total++; if (got_r !== regs(S_RUN, 1, 0, 0)) $display("FAIL load_use_once_regs got=%b exp=%b", got_r, regs(S_RUN, 1, 0, 0)); else n_pass++;
        // consumer in EX, load in WB -> MEM/WB forward
        id_rs = '0; ex_rs = 3'd3; mem_reg_write = '0; mem_wb_we = 1'b0;
        wb_reg_write = 3'd3; wb_wb_we = 1'b1;
        run_cycle(11'b1111_000_01_00);
        n_total++; if (got_c !== want_c) $display("FAIL load_fwd_wb_ctl got=%b exp=%b", got_c, want_c); else n_pass++;
        // ALU producer in EX is forwarded, never stalls
        clear_inputs();
        ex_reg_write = 3'd3; ex_wb_we = 1'b1; id_rs = 3'd3;
        run_cycle(CTL_RUN);
        n_total++; if (got_c !== want_c) $display("FAIL alu_no_stall_ctl got=%b exp=%b", got_c, want_c); else n_pass++;
        clear_inputs();
        ex_mem_read = 1'b1; ex_reg_write = 3'd4; ex_wb_we = 1'b1; id_rt = 3'd4;
        run_cycle(CTL_RUN);
        n_total++; if (got_c !== want_c) $display("FAIL rt_unused_ctl got=%b exp=%b", got_c, want_c); else n_pass++;
        id_uses_rt = 1'b1;
        run_cycle(CTL_STALL);
        n_total++; if (got_c !== want_c) $display("FAIL rt_used_ctl got=%b exp=%b", got_c, want_c); else n_pass++;
        n_total++; if (got_r !== regs(S_RUN, 2, 0, 0)) $display("FAIL rt_used_regs got=%b exp=%b", got_r, regs(S_RUN, 2, 0, 0)); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_forwarding();
        do_reset();
        mem_reg_write = 3'd2; mem_wb_we = 1'b1; wb_reg_write = 3'd2; wb_wb_we = 1'b1; ex_rs = 3'd2;
        run_cycle(11'b1111_000_10_00);
        n_total++; if (got_c !== want_c) $display("FAIL fwd_a_mem got=%b exp=%b", got_c, want_c); else n_pass++;
        mem_wb_we = 1'b0;
        run_cycle(11'b1111_000_01_00);
        n_total++; if (got_c !== want_c) $display("FAIL fwd_a_wb got=%b exp=%b", got_c, want_c); else n_pass++;
        ex_rs = '0; mem_reg_write = '0; mem_wb_we = 1'b1; wb_reg_write = '0;
        run_cycle(CTL_RUN);
        n_total++; if (got_c !== want_c) $display("FAIL fwd_a_r0 got=%b exp=%b", got_c, want_c); else n_pass++;
        clear_inputs();
        ex_rs = 3'd1; ex_rt = 3'd5; mem_reg_write = 3'd5; mem_wb_we = 1'b1;
        wb_reg_write = 3'd1; wb_wb_we = 1'b1;
        run_cycle(11'b1111_000_01_10);
        n_total++; if (got_c !== want_c) $display("FAIL fwd_b_mem got=%b exp=%b", got_c, want_c); else n_pass++;
        mem_busy = 1'b1;
        run_cycle(11'b0000_000_01_10);
        n_total++; if (got_c !== want_c) $display("FAIL fwd_during_wait got=%b exp=%b", got_c, want_c); else n_pass++;
        clear_inputs();
    endtask
`else
    task automatic test_stall_nofwd();
        do_reset();
        ex_reg_write = 3'd5; ex_wb_we = 1'b1; id_rs = 3'd5;
        run_cycle(CTL_STALL);
        n_total++; if (got_c !== want_c) $display("FAIL raw_ex_ctl got=%b exp=%b", got_c, want_c); else n_pass++;
        n_total++; if (got_r !== regs(S_RUN, 1, 0, 0)) $display("FAIL raw_ex_regs got=%b exp=%b", got_r, regs(S_RUN, 1, 0, 0)); else n_pass++;
        ex_reg_write = '0; ex_wb_we = 1'b0; mem_reg_write = 3'd5; mem_wb_we = 1'b1;
        run_cycle(CTL_STALL);
        n_total++; if (got_c !== want_c) $display("FAIL raw_mem_ctl got=%b exp=%b", got_c, want_c); else n_pass++;
        n_total++; if (got_r !== regs(S_RUN, 2, 0, 0)) $display("FAIL raw_mem_regs got=%b exp=%b", got_r, regs(S_RUN, 2, 0, 0)); else n_pass++;
        mem_reg_write = '0; mem_wb_we = 1'b0; wb_reg_write = 3'd5; wb_wb_we = 1'b1;
        run_cycle(CTL_STALL);
        n_total++; if (got_c !== want_c) $display("FAIL raw_wb_ctl got=%b exp=%b", got_c, want_c); else n_pass++;
        n_total++; if (got_r !== regs(S_RUN, 3, 0, 0)) $display("FAIL raw_wb_regs got=%b exp=%b", got_r, regs(S_RUN, 3, 0, 0)); else n_pass++;
        wb_reg_write = '0; wb_wb_we = 1'b0;
        run_cycle(CTL_RUN);
        n_total++; if (got_c !== want_c) $display("FAIL raw_done_ctl got=%b exp=%b", got_c, want_c); else n_pass++;
        n_total++; if (got_r !== regs(S_RUN, 3, 0, 0)) $display("FAIL raw_done_regs got=%b exp=%b", got_r, regs(S_RUN, 3, 0, 0)); else n_pass++;
        clear_inputs();
        id_rt = 3'd4; ex_reg_write = 3'd4; ex_wb_we = 1'b1;
        run_cycle(CTL_RUN);
        n_total++; if (got_c !== want_c) $display("FAIL rt_unused_ctl got=%b exp=%b", got_c, want_c); else n_pass++;
        id_uses_rt = 1'b1;
        run_cycle(CTL_STALL);
        n_total++; if (got_c !== want_c) $display("FAIL rt_used_ctl got=%b exp=%b", got_c, want_c); else n_pass++;
        n_total++; if (got_r !== regs(S_RUN, 4, 0, 0)) $display("FAIL rt_used_regs got=%b exp=%b", got_r, regs(S_RUN, 4, 0, 0)); else n_pass++;
        clear_inputs();
        id_uses_rt = 1'b1; ex_wb_we = 1'b1; mem_wb_we = 1'b1; wb_wb_we = 1'b1;
        run_cycle(CTL_RUN);
        n_total++; if (got_c !== want_c) $display("FAIL r0_no_hazard_ctl got=%b exp=%b", got_c, want_c); else n_pass++;
        clear_inputs();
        id_rs = 3'd6; mem_reg_write = 3'd6; ex_reg_write = 3'd6; wb_reg_write = 3'd6;
        run_cycle(CTL_RUN);
        n_total++; if (got_c !== want_c) $display("FAIL we0_no_hazard_ctl got=%b exp=%b", got_c, want_c); else n_pass++;
        clear_inputs();
        id_rs = 3'd1; ex_rs = 3'd2; ex_rt = 3'd3; mem_reg_write = 3'd2; mem_wb_we = 1'b1;
        wb_reg_write = 3'd3; wb_wb_we = 1'b1;
        run_cycle(CTL_RUN);
        n_total++; if (got_c !== want_c) $display("FAIL fwd_off_ctl got=%b exp=%b", got_c, want_c); else n_pass++;
        n_total++; if (got_r !== regs(S_RUN, 4, 0, 0)) $display("FAIL fwd_off_regs got=%b exp=%b", got_r, regs(S_RUN, 4, 0, 0)); else n_pass++;
        clear_inputs();
    endtask
`endif

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_branch();
        test_wait_watchdog();
        test_busy_branch();
`ifdef FORWARDING_EN
        test_load_use();
        test_forwarding();
`else
        test_stall_nofwd();
`endif
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
